// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// Optional same-cycle forwarding is enabled with REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int MAX_WR    = 8;
  localparam int MAX_AW    = 8;

  typedef logic [$clog2(NREGS_DEF)-1:0] reg_addr_t;
  typedef logic [XLEN_DEF-1:0]          reg_data_t;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } win_t;

  // Highest-indexed enabled port writing nonzero address a.
  function automatic win_t win_port(
    input logic [MAX_WR-1:0]             en,
    input logic [MAX_WR-1:0][MAX_AW-1:0] addr,
    input logic [MAX_AW-1:0]             a
  );
    win_t w;
    w = '0;
    for (int p = 0; p < MAX_WR; p++) begin
      if (en[p] && addr[p] == a && a != '0) begin
        w.hit = 1'b1;
        w.idx = 3'(p);
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one in-flight producer per register.
// Issue sets a bit, writeback clears it; set wins on the same cycle.
module regfile_scoreboard #(
  parameter int NREGS = 32,
  parameter int NWR   = 2,
  parameter int AW    = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              issue_en_i,
  input  logic [AW-1:0]     issue_rd_i,
  input  logic [NWR-1:0]    wr_en_i,
  input  logic [NWR*AW-1:0] wr_addr_i,
  output logic [NREGS-1:0]  busy_o
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [NREGS-1:0] set_v;
  logic [NREGS-1:0] clr_v;

  always_comb begin
    set_v  = '0;
    clr_v  = '0;
    busy_d = busy_q;
    for (int r = 1; r < NREGS; r++) begin
      set_v[r] = issue_en_i && (issue_rd_i == AW'(r));
      for (int p = 0; p < NWR; p++) begin
        if (wr_en_i[p] && wr_addr_i[p*AW +: AW] == AW'(r))
          clr_v[r] = 1'b1;
      end
      if (set_v[r])
        busy_d[r] = 1'b1;
      else if (clr_v[r])
        busy_d[r] = 1'b0;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      busy_q <= '0;
    else
      busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with busy-bit scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  parameter  int NRD   = 2,
  parameter  int NWR   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NRD*AW-1:0]   rs_addr_i,
  output logic [NRD*XLEN-1:0] rs_data_o,
  output logic [NRD-1:0]      rs_busy_o,
  input  logic [NWR-1:0]      wr_en_i,
  input  logic [NWR*AW-1:0]   wr_addr_i,
  input  logic [NWR*XLEN-1:0] wr_data_i,
  input  logic                issue_en_i,
  input  logic [AW-1:0]       issue_rd_i,
  output logic [NREGS-1:0]    busy_o,
  output logic                wr_conflict_o
);

  logic [XLEN-1:0] mem_q [NREGS];
  logic            conflict_q;
  logic            conflict_d;
  logic [AW-1:0]   rd_a [NRD];

  regfile_scoreboard #(
    .NREGS(NREGS),
    .NWR  (NWR),
    .AW   (AW)
  ) u_sb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .issue_en_i(issue_en_i),
    .issue_rd_i(issue_rd_i),
    .wr_en_i   (wr_en_i),
    .wr_addr_i (wr_addr_i),
    .busy_o    (busy_o)
  );

  always_comb begin
    conflict_d = 1'b0;
    for (int i = 0; i < NWR; i++) begin
      for (int j = i + 1; j < NWR; j++) begin
        if (wr_en_i[i] && wr_en_i[j] &&
            wr_addr_i[i*AW +: AW] == wr_addr_i[j*AW +: AW] &&
            wr_addr_i[i*AW +: AW] != '0)
          conflict_d = 1'b1;
      end
    end
  end

  // Ascending port loop: the last nonblocking update, the highest port, wins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < NREGS; r++)
        mem_q[r] <= '0;
      conflict_q <= 1'b0;
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (wr_en_i[p] && wr_addr_i[p*AW +: AW] != '0)
          mem_q[wr_addr_i[p*AW +: AW]] <= wr_data_i[p*XLEN +: XLEN];
      end
      conflict_q <= conflict_d;
    end
  end

  assign wr_conflict_o = conflict_q;

`ifdef REGFILE_BYPASS_EN
  logic [MAX_WR-1:0]             en_pad;
  logic [MAX_WR-1:0][MAX_AW-1:0] addr_pad;
  win_t                          rd_w [NRD];

  always_comb begin
    en_pad   = '0;
    addr_pad = '0;
    for (int p = 0; p < NWR; p++) begin
      en_pad[p]   = wr_en_i[p];
      addr_pad[p] = MAX_AW'(wr_addr_i[p*AW +: AW]);
    end
  end
`endif

  always_comb begin
    for (int k = 0; k < NRD; k++) begin
      rd_a[k] = rs_addr_i[k*AW +: AW];
      rs_data_o[k*XLEN +: XLEN] = mem_q[rd_a[k]];
      rs_busy_o[k] = busy_o[rd_a[k]];
`ifdef REGFILE_BYPASS_EN
      rd_w[k] = win_port(en_pad, addr_pad, MAX_AW'(rd_a[k]));
      if (rd_w[k].hit) begin
        rs_data_o[k*XLEN +: XLEN] =
          wr_data_i[int'(rd_w[k].idx)*XLEN +: XLEN];
        rs_busy_o[k] = issue_en_i && (issue_rd_i == rd_a[k]);
      end
`endif
      if (!rst_ni || rd_a[k] == '0) begin
        rs_data_o[k*XLEN +: XLEN] = '0;
        rs_busy_o[k] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Randomized bench for regfile_mp_sb against an array-based model.
// Follows REGFILE_BYPASS_EN when the build defines it.
module tb_regfile_mp_sb;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                rst_ni;
  logic [NRD*AW-1:0]   rs_addr;
  logic [NRD*XLEN-1:0] rs_data;
  logic [NRD-1:0]      rs_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                issue_en;
  logic [AW-1:0]       issue_rd;
  logic [NREGS-1:0]    busy;
  logic                wr_conflict;

  regfile_mp_sb #(
    .XLEN (XLEN),
    .NREGS(NREGS),
    .NRD  (NRD),
    .NWR  (NWR)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .rs_addr_i    (rs_addr),
    .rs_data_o    (rs_data),
    .rs_busy_o    (rs_busy),
    .wr_en_i      (wr_en),
    .wr_addr_i    (wr_addr),
    .wr_data_i    (wr_data),
    .issue_en_i   (issue_en),
    .issue_rd_i   (issue_rd),
    .busy_o       (busy),
    .wr_conflict_o(wr_conflict)
  );

  always #5 clk = ~clk;

  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_busy [NREGS];
  bit              m_conf;
  int              checks = 0;
  int              errors = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREGS; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
    m_conf = 1'b0;
  endtask

  task automatic clear_in();
    wr_en = '0;
    wr_addr = '0;
    wr_data = '0;
    issue_en = 1'b0;
    issue_rd = '0;
  endtask

  task automatic set_wr(input int p, input int a, input logic [31:0] d);
    wr_en[p] = 1'b1;
    wr_addr[p*AW +: AW] = AW'(a);
    wr_data[p*XLEN +: XLEN] = d;
  endtask

  task automatic set_rs(input int k, input int a);
    rs_addr[k*AW +: AW] = AW'(a);
  endtask

  task automatic compare_all();
    int a;
    logic [XLEN-1:0] ed;
    logic eb;
    logic [NREGS-1:0] ev;
    for (int k = 0; k < NRD; k++) begin
      a = int'(rs_addr[k*AW +: AW]);
      ed = (a == 0) ? '0 : m_regs[a];
      eb = (a != 0) && m_busy[a];
`ifdef REGFILE_BYPASS_EN
      for (int p = NWR - 1; p >= 0; p--) begin
        if (a != 0 && wr_en[p] && int'(wr_addr[p*AW +: AW]) == a) begin
          ed = wr_data[p*XLEN +: XLEN];
          eb = issue_en && int'(issue_rd) == a;
          break;
        end
      end
`endif
      check($sformatf("rd_data%0d", k), 64'(rs_data[k*XLEN +: XLEN]), 64'(ed));
      check($sformatf("rd_busy%0d", k), 64'(rs_busy[k]), 64'(eb));
    end
    for (int r = 0; r < NREGS; r++) ev[r] = m_busy[r];
    check("busy_vec", 64'(busy), 64'(ev));
    check("conflict", 64'(wr_conflict), 64'(m_conf));
  endtask

  task automatic model_update();
    int ai, aj;
    bit clr;
    m_conf = 1'b0;
    for (int i = 0; i < NWR; i++)
      for (int j = i + 1; j < NWR; j++) begin
        ai = int'(wr_addr[i*AW +: AW]);
        aj = int'(wr_addr[j*AW +: AW]);
        if (wr_en[i] && wr_en[j] && ai == aj && ai != 0) m_conf = 1'b1;
      end
    for (int r = 1; r < NREGS; r++) begin
      clr = 1'b0;
      for (int p = 0; p < NWR; p++)
        if (wr_en[p] && int'(wr_addr[p*AW +: AW]) == r) clr = 1'b1;
      if (issue_en && int'(issue_rd) == r) m_busy[r] = 1'b1;
      else if (clr) m_busy[r] = 1'b0;
    end
    for (int p = 0; p < NWR; p++) begin
      ai = int'(wr_addr[p*AW +: AW]);
      if (wr_en[p] && ai != 0) m_regs[ai] = wr_data[p*XLEN +: XLEN];
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
    model_update();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    rs_addr = '0;
    clear_in();
    model_reset();
    set_rs(0, 13);
    set_rs(1, 31);
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_conf", 64'(wr_conflict), 64'd0);
    check("rst_rd0", 64'(rs_data[31:0]), 64'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;

    for (int a = 0; a < NREGS; a++) begin
      set_rs(0, a);
      set_rs(1, NREGS - 1 - a);
      #1;
      check("init_rd0", 64'(rs_data[31:0]), 64'd0);
      check("init_rd1", 64'(rs_data[63:32]), 64'd0);
      check("init_busy", 64'(rs_busy), 64'd0);
    end
    @(posedge clk);
    #1;

    set_wr(0, 5, 32'hDEADBEEF);
    set_rs(0, 1);
    set_rs(1, 2);
    tick();
    clear_in();
    set_rs(0, 5);
    set_rs(1, 5);
    #1;
    check("x5_p0", 64'(rs_data[31:0]), 64'hDEADBEEF);
    check("x5_p1", 64'(rs_data[63:32]), 64'hDEADBEEF);
    set_wr(0, 0, 32'h1234);
    set_rs(1, 0);
    tick();
    clear_in();
    #1;
    check("x0_zero", 64'(rs_data[63:32]), 64'd0);

    set_wr(0, 7, 32'h11);
    set_wr(1, 7, 32'h22);
    tick();
    clear_in();
    set_rs(0, 7);
    #1;
    check("x7_win", 64'(rs_data[31:0]), 64'h22);
    check("conf_hi", 64'(wr_conflict), 64'd1);
    tick();
    check("conf_lo", 64'(wr_conflict), 64'd0);

    issue_en = 1'b1;
    issue_rd = AW'(9);
    tick();
    clear_in();
    check("x9_set", 64'(busy[9]), 64'd1);
    issue_en = 1'b1;
    issue_rd = AW'(9);
    set_wr(1, 9, 32'h99);
    tick();
    clear_in();
    check("x9_hold", 64'(busy[9]), 64'd1);
    set_wr(0, 9, 32'h98);
    tick();
    clear_in();
    check("x9_clr", 64'(busy[9]), 64'd0);

    issue_en = 1'b1;
    issue_rd = AW'(3);
    tick();
    clear_in();
    set_wr(0, 3, 32'hA5A5A5A5);
    set_rs(0, 3);
    #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_data", 64'(rs_data[31:0]), 64'hA5A5A5A5);
    check("byp_busy", 64'(rs_busy[0]), 64'd0);
`else
    check("byp_data", 64'(rs_data[31:0]), 64'd0);
    check("byp_busy", 64'(rs_busy[0]), 64'd1);
`endif
    tick();
    clear_in();

    repeat (400) begin
      for (int p = 0; p < NWR; p++) begin
        wr_en[p] = 1'($urandom_range(0, 1));
        wr_addr[p*AW +: AW] = AW'($urandom_range(0, 7));
        wr_data[p*XLEN +: XLEN] = $urandom;
      end
      issue_en = 1'($urandom_range(0, 1));
      issue_rd = AW'($urandom_range(0, 7));
      for (int k = 0; k < NRD; k++) set_rs(k, $urandom_range(0, 7));
      tick();
    end
    clear_in();

    set_wr(0, 5, 32'hCAFEF00D);
    issue_en = 1'b1;
    issue_rd = AW'(12);
    tick();
    clear_in();
    set_wr(1, 11, 32'h55);
    issue_en = 1'b1;
    issue_rd = AW'(13);
    set_rs(0, 5);
    set_rs(1, 12);
    #2;
    rst_ni = 1'b0;
    #1;
    check("mid_busy", 64'(busy), 64'd0);
    check("mid_x5", 64'(rs_data[31:0]), 64'd0);
    check("mid_rsbusy", 64'(rs_busy), 64'd0);
    check("mid_conf", 64'(wr_conflict), 64'd0);
    clear_in();
    model_reset();
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
    set_rs(0, 11);
    set_rs(1, 5);
    #1;
    check("post_x11", 64'(rs_data[31:0]), 64'd0);
    check("post_x5", 64'(rs_data[63:32]), 64'd0);
    check("post_busy", 64'(busy), 64'd0);
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised multi-port integer register file for the pipelined core, with an integrated busy-bit scoreboard.
- Serves NRD combinational read ports (decode/issue) and NWR synchronous write ports (writeback lanes).
- Tracks destination registers with in-flight producers so issue logic can stall on RAW hazards.
- Register 0 is hardwired to zero and is never busy.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; power of two, ≥ 2.
- NRD, 2, number of read ports.
- NWR, 2, number of write ports.
- AW, $clog2(NREGS), address width; derived, not overridden.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- rs_addr_i  in  NRD*AW  packed read addresses; port k occupies bits [k*AW +: AW].
- rs_data_o  out  NRD*XLEN  packed read data.
- rs_busy_o  out  NRD  per-read-port busy flag (RAW hazard pending).
- wr_en_i  in  NWR  per-port write enable.
- wr_addr_i  in  NWR*AW  packed write addresses.
- wr_data_i  in  NWR*XLEN  packed write data.
- issue_en_i  in  1  an instruction with a destination register issues this cycle.
- issue_rd_i  in  AW  destination of the issuing instruction.
- busy_o  out  NREGS  full scoreboard vector.
- wr_conflict_o  out  1  registered pulse: two or more enabled write ports targeted the same nonzero address in the previous cycle.

Behaviour:
- Reset (asynchronous, while rst_ni=0):
  - all registers = 0; busy_o = 0; wr_conflict_o = 0.
  - rs_data_o = 0 and rs_busy_o = 0 for any address.
  - Reset asserted mid-operation discards pending writes and busy bits immediately.
- Reads: combinational, zero latency.
  - Address 0 always returns data 0 and busy 0.
- Writes: take effect at the rising edge; visible on reads the cycle after.
  - Writes to address 0 are ignored.
- Write collision: several enabled ports on the same address.
  - The highest-indexed port wins.
  - wr_conflict_o = 1 for exactly the next cycle; no other side effect.
- Scoreboard, per register r ≠ 0, next state:
  - set if issue_en_i and issue_rd_i == r;
  - else clear if any enabled write port targets r;
  - else hold.
  - Set has priority over clear on the same cycle: the new producer supersedes the retiring one.
- issue_en_i with issue_rd_i == 0 has no effect.
- Issue on an already-busy register keeps it busy (WAW); the first writeback clears it. Only one in-flight producer per register is tracked.
- busy_o[0] is constant 0.
- rs_busy_o[k] = busy_o[rs_addr_k], modified by the optional feature below.
- No handshake on write ports; the upstream guarantees at most one writeback per lane per cycle.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined — same-cycle write-to-read forwarding:
  - If any enabled write port targets rs_addr_k (nonzero), rs_data_o[k] = wr_data of the highest-indexed such port.
  - rs_busy_o[k] = 0 unless issue_en_i targets the same address this cycle.
  - Forwarding is purely combinational; stored state is unchanged.
- Undefined:
  - Reads return stored contents only; a same-cycle write is seen one cycle later.
  - rs_busy_o[k] reflects the registered busy bit only.

Decomposition:
- Package regfile_pkg holds:
  - XLEN and NREGS defaults;
  - the reg_addr_t / reg_data_t typedefs;
  - a function returning the winning write-port index for a given address.
- Sub-module regfile_scoreboard (NREGS, NWR, AW): owns the busy vector and set/clear priority.
- The top module holds the storage array, read muxes, collision detection and the optional bypass.

Test Plan:
- Reset → read all 32 addresses → 0 data, busy_o = 0, wr_conflict_o = 0.
- Write x5 = 0xDEADBEEF on port 0, then read x5 on both read ports the next cycle → 0xDEADBEEF. Write x0 = 0x1234 → x0 still reads 0.
- Same cycle: port 0 writes x7 = 0x11 and port 1 writes x7 = 0x22 → x7 = 0x22; wr_conflict_o high for one cycle only.
- Issue x9 → busy_o[9] = 1 the next cycle. Writeback x9 together with a new issue of x9 in the same cycle → busy_o[9] stays 1. A later writeback with no issue → busy_o[9] = 0.
- With REGFILE_BYPASS_EN: write x3 = 0xA5A5A5A5 and read x3 in the same cycle → rs_data_o = 0xA5A5A5A5, rs_busy_o = 0. Without the macro → old value, and the busy bit as stored.
- Assert rst_ni mid-stream with busy bits set and writes pending → busy_o and all registers 0 immediately; the pending write is not applied after reset release.
